// File: rtl/fmac_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// fmac_issue_arbiter_if
// Bundles the requester-side handshake, the FMAC issue/return bus and the
// status outputs of fmac_issue_arbiter.
//   slave  : the arbiter itself
//   master : the surrounding environment (requesters + FMAC datapath)
// Signals:
//   Enable_SI, Flush_SI            grant permit / in-flight kill
//   Req_Valid_SI / Req_Ready_SO    per-requester handshake (one bit each)
//   Req_OpA/OpB/OpC_DI, Req_RM_DI  packed operands, requester i at slice i
//   Fmac_Valid_SO, Fmac_Op*_DO,
//   Fmac_RM_DO                     registered issue to the FMAC
//   Fmac_Valid_SI, Fmac_Result_DI  FMAC return
//   Resp_Valid_SO, Resp_Result_DO  one-hot routed response
//   Busy_SO, Err_SO                status
// ---------------------------------------------------------------------------
interface fmac_issue_arbiter_if #(
  parameter int unsigned C_NUM_REQ = 2,
  parameter int unsigned C_OP      = 32,
  parameter int unsigned C_RM      = 2
);
  logic                          Enable_SI;
  logic                          Flush_SI;
  logic [C_NUM_REQ-1:0]          Req_Valid_SI;
  logic [C_NUM_REQ-1:0]          Req_Ready_SO;
  logic [C_NUM_REQ*C_OP-1:0]     Req_OpA_DI;
  logic [C_NUM_REQ*C_OP-1:0]     Req_OpB_DI;
  logic [C_NUM_REQ*C_OP-1:0]     Req_OpC_DI;
  logic [C_NUM_REQ*C_RM-1:0]     Req_RM_DI;
  logic                          Fmac_Valid_SO;
  logic [C_OP-1:0]               Fmac_OpA_DO;
  logic [C_OP-1:0]               Fmac_OpB_DO;
  logic [C_OP-1:0]               Fmac_OpC_DO;
  logic [C_RM-1:0]               Fmac_RM_DO;
  logic                          Fmac_Valid_SI;
  logic [C_OP-1:0]               Fmac_Result_DI;
  logic [C_NUM_REQ-1:0]          Resp_Valid_SO;
  logic [C_OP-1:0]               Resp_Result_DO;
  logic                          Busy_SO;
  logic                          Err_SO;

  modport slave (
    input  Enable_SI, Flush_SI, Req_Valid_SI,
    input  Req_OpA_DI, Req_OpB_DI, Req_OpC_DI, Req_RM_DI,
    input  Fmac_Valid_SI, Fmac_Result_DI,
    output Req_Ready_SO,
    output Fmac_Valid_SO, Fmac_OpA_DO, Fmac_OpB_DO, Fmac_OpC_DO, Fmac_RM_DO,
    output Resp_Valid_SO, Resp_Result_DO, Busy_SO, Err_SO
  );

  modport master (
    output Enable_SI, Flush_SI, Req_Valid_SI,
    output Req_OpA_DI, Req_OpB_DI, Req_OpC_DI, Req_RM_DI,
    output Fmac_Valid_SI, Fmac_Result_DI,
    input  Req_Ready_SO,
    input  Fmac_Valid_SO, Fmac_OpA_DO, Fmac_OpB_DO, Fmac_OpC_DO, Fmac_RM_DO,
    input  Resp_Valid_SO, Resp_Result_DO, Busy_SO, Err_SO
  );
endinterface

// File: rtl/fmac_issue_arbiter.sv
// ---------------------------------------------------------------------------
// fmac_issue_arbiter
// Shares one pipelined FMAC between C_NUM_REQ requesters. A round-robin
// grant picks one valid requester per cycle, its operands and rounding mode
// are registered onto the FMAC input, and a tag pipe carries the owner ID
// alongside the operation so the FMAC result can be routed back one-hot.
// Ports:
//   Clk_CI   clock
//   Rst_RBI  asynchronous active-low reset
//   bus      fmac_issue_arbiter_if.slave (handshake, FMAC bus, status)
// ---------------------------------------------------------------------------
module fmac_issue_arbiter #(
  parameter int unsigned C_NUM_REQ  = 2,
  parameter int unsigned C_REQ_IDX  = 1,
  parameter int unsigned C_OP       = 32,
  parameter int unsigned C_RM       = 2,
  parameter int unsigned C_FMAC_LAT = 3
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RBI,
  fmac_issue_arbiter_if.slave  bus
);

  // Stage 0 holds the op during its issue cycle (Fmac_Valid_SO high); the
  // following C_FMAC_LAT stages mirror the FMAC latency, so the last stage
  // lines up with Fmac_Valid_SI for that op.
  localparam int unsigned C_STG = C_FMAC_LAT + 1;

  typedef struct packed {
    logic                 live;
    logic                 killed;
    logic [C_REQ_IDX-1:0] id;
  } tag_t;

  tag_t                   tag_q [C_STG];
  tag_t                   tag_d [C_STG];
  tag_t                   last_tag;

  logic [C_REQ_IDX-1:0]   ptr_q, ptr_d;
  logic [C_OP-1:0]        opa_q, opa_d;
  logic [C_OP-1:0]        opb_q, opb_d;
  logic [C_OP-1:0]        opc_q, opc_d;
  logic [C_RM-1:0]        rm_q, rm_d;
  logic                   fv_q, fv_d;
  logic [C_NUM_REQ-1:0]   resp_vld_q, resp_vld_d;
  logic [C_OP-1:0]        resp_res_q, resp_res_d;
  logic                   err_q, err_d;

  logic                   gnt_vld;
  logic [C_REQ_IDX-1:0]   gnt_idx;
  logic [C_NUM_REQ-1:0]   ready;
  logic                   any_live;
  int unsigned            cand;

  // Round-robin search starting at the pointer, wrapping modulo C_NUM_REQ
  // (C_NUM_REQ need not be a power of two, so the wrap is explicit).
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    if (bus.Enable_SI && !bus.Flush_SI) begin
      for (int unsigned k = 0; k < C_NUM_REQ; k++) begin
        cand = {{(32-C_REQ_IDX){1'b0}}, ptr_q} + k;
        if (cand >= C_NUM_REQ) cand = cand - C_NUM_REQ;
        if (!gnt_vld && bus.Req_Valid_SI[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = C_REQ_IDX'(cand);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (gnt_vld) ready[gnt_idx] = 1'b1;
  end

  assign last_tag = tag_q[C_STG-1];

  always_comb begin
    ptr_d      = ptr_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    opc_d      = opc_q;
    rm_d       = rm_q;
    fv_d       = gnt_vld;
    resp_vld_d = '0;
    resp_res_d = resp_res_q;

    if (gnt_vld) begin
      ptr_d = (32'(gnt_idx) == C_NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      opa_d = bus.Req_OpA_DI[gnt_idx*C_OP +: C_OP];
      opb_d = bus.Req_OpB_DI[gnt_idx*C_OP +: C_OP];
      opc_d = bus.Req_OpC_DI[gnt_idx*C_OP +: C_OP];
      rm_d  = bus.Req_RM_DI[gnt_idx*C_RM +: C_RM];
    end

    // The FMAC cannot stall, so the tag pipe shifts every cycle.
    tag_d[0].live   = gnt_vld;
    tag_d[0].killed = 1'b0;
    tag_d[0].id     = gnt_idx;
    for (int unsigned s = 1; s < C_STG; s++) begin
      tag_d[s] = tag_q[s-1];
      if (bus.Flush_SI && tag_q[s-1].live) tag_d[s].killed = 1'b1;
    end

    // A flush also suppresses the response that would leave this cycle.
    if (last_tag.live && !last_tag.killed && !bus.Flush_SI) begin
      resp_vld_d[last_tag.id] = 1'b1;
      resp_res_d              = bus.Fmac_Result_DI;
    end

    // The FMAC must return exactly when the last stage holds an op,
    // killed or not.
    err_d = err_q | (bus.Fmac_Valid_SI != last_tag.live);
  end

  always_comb begin
    any_live = 1'b0;
    for (int unsigned s = 0; s < C_STG; s++) begin
      any_live = any_live | tag_q[s].live;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q      <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      opc_q      <= '0;
      rm_q       <= '0;
      fv_q       <= 1'b0;
      resp_vld_q <= '0;
      resp_res_q <= '0;
      err_q      <= 1'b0;
      for (int unsigned s = 0; s < C_STG; s++) tag_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      opc_q      <= opc_d;
      rm_q       <= rm_d;
      fv_q       <= fv_d;
      resp_vld_q <= resp_vld_d;
      resp_res_q <= resp_res_d;
      err_q      <= err_d;
      for (int unsigned s = 0; s < C_STG; s++) tag_q[s] <= tag_d[s];
    end
  end

  assign bus.Req_Ready_SO   = ready;
  assign bus.Fmac_Valid_SO  = fv_q;
  assign bus.Fmac_OpA_DO    = opa_q;
  assign bus.Fmac_OpB_DO    = opb_q;
  assign bus.Fmac_OpC_DO    = opc_q;
  assign bus.Fmac_RM_DO     = rm_q;
  assign bus.Resp_Valid_SO  = resp_vld_q;
  assign bus.Resp_Result_DO = resp_res_q;
  assign bus.Busy_SO        = fv_q | any_live;
  assign bus.Err_SO         = err_q;

endmodule

// File: tb/tb_fmac_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fmac_issue_arbiter
// Drives requests, models the FMAC as a fixed-latency return pipe, and checks
// grants, issue strobes, routed responses, Busy and Err against a reference
// model built from the round-robin / latency / flush rules.
// ---------------------------------------------------------------------------
module tb_fmac_issue_arbiter;
  localparam int N   = 2;
  localparam int IW  = 1;
  localparam int OPW = 32;
  localparam int RMW = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmac_issue_arbiter_if #(.C_NUM_REQ(N), .C_OP(OPW), .C_RM(RMW)) bus ();

  fmac_issue_arbiter #(
    .C_NUM_REQ(N), .C_REQ_IDX(IW), .C_OP(OPW), .C_RM(RMW), .C_FMAC_LAT(LAT)
  ) dut (
    .Clk_CI (clk),
    .Rst_RBI(rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          issue;
    int          due;
    int          id;
    logic [31:0] res;
    bit          killed;
  } exp_t;

  exp_t pend[$];
  int   ptr_m    = 0;
  int   err_from = -1;
  bit   mon_en   = 1'b0;
  bit   inj      = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Single-precision via double arithmetic; truncating, enough for a stub.
  function automatic real sp2r(input logic [31:0] x);
    logic [10:0] e;
    if (x[30:23] == 8'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    return $bitstoreal({x[31], e, x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] b;
    logic [10:0] e;
    logic [7:0]  e8;
    b = $realtobits(r);
    e = b[62:52];
    if (e <= 11'd896) return {b[63], 31'b0};
    if (e >= 11'd1151) return {b[63], 8'hFF, 23'b0};
    e8 = 8'(e - 11'd896);
    return {b[63], e8, b[51:29]};
  endfunction

  function automatic logic [31:0] fmac_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [1:0] rm);
    return r2sp(sp2r(a) * sp2r(b) + sp2r(c)) ^ {30'b0, rm};
  endfunction

  // FMAC stub: returns each issued op LAT cycles after its issue cycle.
  logic [32:0] fpipe[$];
  logic [32:0] fe;
  initial begin
    bus.Fmac_Valid_SI  = 1'b0;
    bus.Fmac_Result_DI = '0;
    forever begin
      @(negedge clk);
      fe = '0;
      if (!rst_n) begin
        fpipe.delete();
      end else begin
        fpipe.push_back({bus.Fmac_Valid_SO,
                         fmac_fn(bus.Fmac_OpA_DO, bus.Fmac_OpB_DO, bus.Fmac_OpC_DO, bus.Fmac_RM_DO)});
        if (fpipe.size() > LAT) fe = fpipe.pop_front();
      end
      bus.Fmac_Valid_SI  = fe[32] | inj;
      bus.Fmac_Result_DI = fe[31:0];
    end
  end

  // Monitor: pops the scoreboard when a response is due and checks status.
  exp_t         h;
  logic [N-1:0] m_rv;
  logic [31:0]  m_res;
  bit           m_ev, m_busy, m_fv, m_err;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        m_rv = '0; m_res = '0; m_ev = 1'b0; m_busy = 1'b0; m_fv = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          h = pend.pop_front();
          if (!h.killed) begin
            m_rv[h.id] = 1'b1;
            m_res = h.res;
            m_ev = 1'b1;
          end
        end
        foreach (pend[i]) begin
          if (pend[i].issue < cyc) m_busy = 1'b1;
          if (pend[i].issue == cyc - 1) m_fv = 1'b1;
        end
        m_err = (err_from >= 0) && (cyc >= err_from);
        check("resp_valid", bus.Resp_Valid_SO, m_rv);
        if (m_ev) check("resp_result", bus.Resp_Result_DO, m_res);
        check("fmac_valid", bus.Fmac_Valid_SO, m_fv);
        check("busy", bus.Busy_SO, m_busy);
        check("err", bus.Err_SO, m_err);
      end
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      bus.Req_OpA_DI[i*OPW +: OPW] = $urandom;
      bus.Req_OpB_DI[i*OPW +: OPW] = $urandom;
      bus.Req_OpC_DI[i*OPW +: OPW] = $urandom;
      bus.Req_RM_DI[i*RMW +: RMW]  = RMW'($urandom);
    end
  endtask

  // One cycle: drive, evaluate the reference grant at the negedge, advance.
  task automatic step(input logic [N-1:0] v, input bit en, input bit fl);
    int g;
    int idx;
    logic [N-1:0] rdy;
    exp_t e;
    bus.Req_Valid_SI = v;
    bus.Enable_SI    = en;
    bus.Flush_SI     = fl;
    @(negedge clk);
    if (!rst_n) begin
      pend.delete();
      ptr_m = 0;
    end else begin
      g = -1;
      if (en && !fl) begin
        for (int k = 0; k < N; k++) begin
          idx = (ptr_m + k) % N;
          if (g < 0 && v[idx]) g = idx;
        end
      end
      rdy = '0;
      if (g >= 0) rdy[g] = 1'b1;
      check("grant", bus.Req_Ready_SO, rdy);
      if (fl) begin
        foreach (pend[i]) if (pend[i].due > cyc) pend[i].killed = 1'b1;
      end
      if (g >= 0) begin
        e.issue  = cyc;
        e.due    = cyc + 2 + LAT;
        e.id     = g;
        e.res    = fmac_fn(bus.Req_OpA_DI[g*OPW +: OPW], bus.Req_OpB_DI[g*OPW +: OPW],
                           bus.Req_OpC_DI[g*OPW +: OPW], bus.Req_RM_DI[g*RMW +: RMW]);
        e.killed = 1'b0;
        pend.push_back(e);
        ptr_m = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.Req_Valid_SI = '0;
    bus.Enable_SI    = 1'b0;
    bus.Flush_SI     = 1'b0;
    bus.Req_OpA_DI   = '0;
    bus.Req_OpB_DI   = '0;
    bus.Req_OpC_DI   = '0;
    bus.Req_RM_DI    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.Req_Ready_SO, 0);
    check("rst_fmac_valid", bus.Fmac_Valid_SO, 0);
    check("rst_opa", bus.Fmac_OpA_DO, 0);
    check("rst_resp_valid", bus.Resp_Valid_SO, 0);
    check("rst_resp_result", bus.Resp_Result_DO, 0);
    check("rst_busy", bus.Busy_SO, 0);
    check("rst_err", bus.Err_SO, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single op from requester 1: 1.0 * 2.0 + 0.0
    bus.Req_OpA_DI = {32'h3F80_0000, 32'h0};
    bus.Req_OpB_DI = {32'h4000_0000, 32'h0};
    bus.Req_OpC_DI = '0;
    bus.Req_RM_DI  = '0;
    step(2'b10, 1'b1, 1'b0);
    bus.Req_OpA_DI = '0;
    idle(4);
    check("single_result", bus.Resp_Result_DO, 32'h4000_0000);
    check("single_valid", bus.Resp_Valid_SO, 2'b10);
    idle(3);

    // Both requesters contending: strict alternation
    for (int i = 0; i < 4; i++) begin rand_ops(); step(2'b11, 1'b1, 1'b0); end
    idle(7);

    // Move the pointer to 1, then only requester 0 (wrap every cycle)
    rand_ops(); step(2'b01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin rand_ops(); step(2'b01, 1'b1, 1'b0); end
    idle(7);

    // Three back-to-back issues, flush right after the third
    for (int i = 0; i < 3; i++) begin rand_ops(); step(2'b11, 1'b1, 1'b0); end
    step(2'b11, 1'b1, 1'b1);
    idle(8);

    // Enable low blocks grants; raising it grants at the pointer
    for (int i = 0; i < 4; i++) begin rand_ops(); step(2'b11, 1'b0, 1'b0); end
    rand_ops(); step(2'b11, 1'b1, 1'b0);
    idle(7);

    // Random traffic with occasional enable drops and flushes
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      step(N'($urandom), ($urandom % 8) != 0, ($urandom % 16) == 0);
    end
    idle(8);

    // Spurious FMAC return with an empty tag pipe sets the sticky error
    inj = 1'b1;
    err_from = cyc + 1;
    step('0, 1'b1, 1'b0);
    inj = 1'b0;
    idle(5);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    err_from = -1;
    step('0, 1'b1, 1'b0);
    check("err_cleared_by_reset", bus.Err_SO, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(3);

    check("scoreboard_drained", pend.size(), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
